// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin front end that shares one iterative AES-128
// ECB engine between NUM_REQ requesters. One block in flight at a time; the
// result comes back tagged with the owning requester ID on a valid/ready port.
// Optional engine watchdog: define AES_CORE_ARBITER_TIMEOUT_EN.
module aes_core_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  input  logic [NUM_REQ-1:0]     req_mode,
  output logic                   core_start,
  output logic [127:0]           core_din,
  output logic [127:0]           core_key,
  output logic                   core_mode,
  input  logic                   core_done,
  input  logic [127:0]           core_dout,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [127:0]           resp_data,
  output logic                   resp_err
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CW    = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   gid_q;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   ptr_next;
  logic              grant_found;
  logic [BLK_W-1:0]  sel_din;
  logic [BLK_W-1:0]  sel_key;
  logic              sel_mode;
  logic              load;
  logic              capture;
  logic              accept;
  logic              timeout_hit;

  // Reject out-of-range configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("aes_core_arbiter: parameter out of range");
  end

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin : grant_search
    logic [CW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = CW'({1'b0, ptr_q}) + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping to 0.
  always_comb begin : ptr_advance
    logic [CW-1:0] nxt;
    nxt = CW'({1'b0, grant_idx}) + CW'(1);
    if (nxt >= CW'(NUM_REQ)) begin
      nxt = '0;
    end
    ptr_next = nxt[ID_W-1:0];
  end

  // Payload mux for the winning requester (constant slices only).
  always_comb begin
    sel_din  = '0;
    sel_key  = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_din  = req_data[i*BLK_W +: BLK_W];
        sel_key  = req_key[i*BLK_W +: BLK_W];
        sel_mode = req_mode[i];
      end
    end
  end

`ifdef AES_CORE_ARBITER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Watchdog: cleared while issuing, counts every BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == BUSY) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // Fires on the edge where the count would reach the limit; a done pulse wins.
  assign timeout_hit = (state_q == BUSY) && !core_done &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          load      = 1'b1;
          req_ready = NUM_REQ'(1) << grant_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (core_done || timeout_hit) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the granted request; start pulse lines up with the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_start <= 1'b0;
      core_din   <= '0;
      core_key   <= '0;
      core_mode  <= 1'b0;
      gid_q      <= '0;
      ptr_q      <= '0;
    end else begin
      core_start <= load;
      if (load) begin
        core_din  <= sel_din;
        core_key  <= sel_key;
        core_mode <= sel_mode;
        gid_q     <= grant_idx;
        ptr_q     <= ptr_next;
      end
    end
  end

  // Response register: filled from the engine (or watchdog), held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (capture) begin
      resp_valid <= 1'b1;
      resp_id    <= gid_q;
      resp_data  <= timeout_hit ? '0 : core_dout;
      resp_err   <= timeout_hit;
    end else if (accept) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural engine stand-in with 10-cycle
// latency, scoreboard of expected responses popped on each handshake.
module tb_aes_core_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned ENG_LAT = 10;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_data = '0;
  logic [NUM_REQ*128-1:0] req_key = '0;
  logic [NUM_REQ-1:0]     req_mode = '0;
  logic                   core_start;
  logic [127:0]           core_din;
  logic [127:0]           core_key;
  logic                   core_mode;
  logic                   core_done = 1'b0;
  logic [127:0]           core_dout = '0;
  logic                   resp_valid;
  logic                   resp_ready = 1'b0;
  logic [ID_W-1:0]        resp_id;
  logic [127:0]           resp_data;
  logic                   resp_err;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [127:0]    data;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_resp = 0;
  int   start_count = 0;
  int   grant_count = 0;
  logic eng_hang = 1'b0;
  int   eng_cnt = 0;
  logic [127:0] eng_res = '0;

  logic [127:0] tb_d [NUM_REQ];
  logic [127:0] tb_k [NUM_REQ];
  logic         tb_m [NUM_REQ];

  aes_core_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_key    (req_key),
    .req_mode   (req_mode),
    .core_start (core_start),
    .core_din   (core_din),
    .core_key   (core_key),
    .core_mode  (core_mode),
    .core_done  (core_done),
    .core_dout  (core_dout),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Engine stand-in: knows the FIPS-197 pair, otherwise a reversible mix.
  function automatic logic [127:0] eng_model(input logic [127:0] din, input logic [127:0] key,
                                             input logic mode);
    if (key == FIPS_KEY && !mode && din == FIPS_PT) return FIPS_CT;
    if (key == FIPS_KEY && mode && din == FIPS_CT) return FIPS_PT;
    return din ^ {key[63:0], key[127:64]} ^ {128{mode}};
  endfunction

  // Engine: not reset by rst_n, so an in-flight block still pulses done late.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        core_done = 1'b1;
        core_dout = eng_res;
      end
    end else if (core_start && !eng_hang) begin
      eng_cnt = ENG_LAT;
      eng_res = eng_model(core_din, core_key, core_mode);
    end
  end

  // Activity counters.
  always @(negedge clk) begin
    if (core_start) start_count++;
    if (rst_n && req_ready != '0) grant_count++;
  end

  // Response monitor: every handshake pops one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      n_resp++;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp: got id %0d data %h, exp no response", resp_id, resp_data);
      end else begin
        e = sb.pop_front();
        n_tests++;
        if (resp_id !== e.id) begin
          n_fail++; $display("FAIL resp_id: got %0d exp %0d", resp_id, e.id);
        end
        n_tests++;
        if (resp_data !== e.data) begin
          n_fail++; $display("FAIL resp_data: got %h exp %h", resp_data, e.data);
        end
        n_tests++;
        if (resp_err !== e.err) begin
          n_fail++; $display("FAIL resp_err: got %0b exp %0b", resp_err, e.err);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [127:0] d, input logic [127:0] k, input logic m);
    tb_d[i] = d; tb_k[i] = k; tb_m[i] = m;
    req_data[i*128 +: 128] = d;
    req_key[i*128 +: 128]  = k;
    req_mode[i]            = m;
  endtask

  task automatic push_exp(input int id, input logic [127:0] d, input logic err);
    exp_t e;
    e.id = ID_W'(id); e.data = d; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_resp(input int target, input int limit, input string name);
    int cyc = 0;
    while (n_resp < target && cyc < limit) begin
      @(posedge clk); #1; cyc++;
    end
    if (n_resp < target) begin
      n_tests++; n_fail++;
      $display("FAIL %s_wait: got %0d responses exp %0d", name, n_resp, target);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({resp_valid, core_start, core_mode, resp_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 0000", {resp_valid, core_start, core_mode, resp_err});
    end
    n_tests++;
    if ({core_din, core_key, resp_data} !== 384'd0) begin
      n_fail++; $display("FAIL reset_data: got din %h key %h rdata %h exp 0", core_din, core_key, resp_data);
    end
    n_tests++;
    if (resp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_resp_id: got %0d exp 0", resp_id);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL idle_req_ready: got %b exp 0000", req_ready);
    end
  endtask

  task automatic test_fips_encrypt();
    int base = n_resp;
    set_req(2, FIPS_PT, FIPS_KEY, 1'b0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b0100;
    push_exp(2, FIPS_CT, 1'b0);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL fips_req_ready: got %b exp 0100", req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    n_tests++;
    if ({core_start, core_mode} !== 2'b10) begin
      n_fail++; $display("FAIL fips_issue: got start/mode %b exp 10", {core_start, core_mode});
    end
    n_tests++;
    if (core_din !== FIPS_PT || core_key !== FIPS_KEY) begin
      n_fail++; $display("FAIL fips_core_bus: got din %h key %h exp %h %h", core_din, core_key, FIPS_PT, FIPS_KEY);
    end
    wait_resp(base + 1, 40, "fips");
  endtask

  task automatic test_decrypt();
    int base = n_resp;
    set_req(1, FIPS_CT, FIPS_KEY, 1'b1);
    req_valid = 4'b0010;
    push_exp(1, FIPS_PT, 1'b0);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL dec_req_ready: got %b exp 0010", req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    wait_resp(base + 1, 40, "decrypt");
  endtask

  task automatic test_fairness();
    int base, g0, s0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(i, {4{32'ha5a50000 + 32'(i)}}, {4{32'h00001000 + 32'(i * 7)}}, (i % 2) == 1);
    end
    for (int n = 0; n < 6; n++) begin
      push_exp(n % 4, eng_model(tb_d[n % 4], tb_k[n % 4], tb_m[n % 4]), 1'b0);
    end
    base = n_resp; g0 = grant_count; s0 = start_count;
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    wait_resp(base + 6, 300, "fairness");
    req_valid = '0;
    n_tests++;
    if (grant_count - g0 !== 6) begin
      n_fail++; $display("FAIL fair_grants: got %0d exp 6", grant_count - g0);
    end
    n_tests++;
    if (start_count - s0 !== 6) begin
      n_fail++; $display("FAIL fair_starts: got %0d exp 6", start_count - s0);
    end
  endtask

  task automatic test_backpressure();
    int base = n_resp;
    int s0;
    int cyc = 0;
    logic [127:0] exp2;
    exp2 = eng_model(tb_d[2], tb_k[2], tb_m[2]);
    push_exp(2, exp2, 1'b0);
    push_exp(3, eng_model(tb_d[3], tb_k[3], tb_m[3]), 1'b0);
    resp_ready = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    while (!resp_valid && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    s0 = start_count;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if ({resp_valid, resp_id} !== {1'b1, 2'd2}) begin
        n_fail++; $display("FAIL bp_hold_id cyc %0d: got valid %0b id %0d exp 1 2", i, resp_valid, resp_id);
      end
      n_tests++;
      if (resp_data !== exp2) begin
        n_fail++; $display("FAIL bp_hold_data cyc %0d: got %h exp %h", i, resp_data, exp2);
      end
      n_tests++;
      if ({req_ready, core_start} !== 5'b0) begin
        n_fail++; $display("FAIL bp_quiet cyc %0d: got ready %b start %0b exp 0", i, req_ready, core_start);
      end
    end
    n_tests++;
    if (start_count !== s0) begin
      n_fail++; $display("FAIL bp_starts: got %0d exp %0d", start_count, s0);
    end
    @(posedge clk); #1; resp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_accept_cycle_ready: got %b exp 0000", req_ready);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_next_grant: got %b exp 1000", req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    wait_resp(base + 2, 40, "backpressure");
  endtask

  task automatic test_reset_mid();
    int n0;
    logic saw_valid = 1'b0;
    set_req(1, 128'h0123456789abcdef0123456789abcdef, 128'hfedcba9876543210fedcba9876543210, 1'b0);
    set_req(3, 128'h3333333333333333cccccccccccccccc, 128'h0f0f0f0f0f0f0f0ff0f0f0f0f0f0f0f0, 1'b1);
    req_valid = 4'b0010;
    @(posedge clk); #1; req_valid = '0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({resp_valid, core_start, core_mode, resp_err, req_ready} !== 8'd0) begin
      n_fail++; $display("FAIL midrst_flags: got %b exp 0", {resp_valid, core_start, core_mode, resp_err, req_ready});
    end
    n_tests++;
    if ({core_din, core_key, resp_data, resp_id} !== 386'd0) begin
      n_fail++; $display("FAIL midrst_data: got din %h key %h id %0d exp 0", core_din, core_key, resp_id);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    n0 = n_resp;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid) saw_valid = 1'b1;
    end
    n_tests++;
    if (saw_valid !== 1'b0 || n_resp !== n0) begin
      n_fail++; $display("FAIL midrst_late_done: got valid_seen %0b resp %0d exp 0 %0d", saw_valid, n_resp, n0);
    end
    @(posedge clk); #1;
    req_valid = 4'b1010;
    push_exp(1, eng_model(tb_d[1], tb_k[1], tb_m[1]), 1'b0);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL midrst_lowest_grant: got %b exp 0010", req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    wait_resp(n0 + 1, 40, "midrst");
  endtask

`ifdef AES_CORE_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int base = n_resp;
    eng_hang = 1'b1;
    set_req(0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, FIPS_KEY, 1'b0);
    resp_ready = 1'b1;
    req_valid = 4'b0001;
    push_exp(0, 128'd0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (core_start !== 1'b1) begin
      n_fail++; $display("FAIL tmo_issue: got start %0b exp 1", core_start);
    end
    repeat (64) @(negedge clk);
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_early: got valid %0b exp 0 at busy+63", resp_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({resp_valid, resp_err} !== 2'b11 || resp_data !== 128'd0) begin
      n_fail++; $display("FAIL tmo_resp: got valid/err %b data %h exp 11 0", {resp_valid, resp_err}, resp_data);
    end
    @(posedge clk); #1; eng_hang = 1'b0;
    wait_resp(base + 1, 10, "timeout");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no finish exp finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fips_encrypt();
    test_decrypt();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef AES_CORE_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
